// File: rtl/shot_tracer.sv
// Shot tracer: latches the aim vector on a fire edge and walks the shot across a
// 32x32 field with an integer Bresenham stepper. Optional macro SHOT_BOUNCE_EN
// makes the side walls reflect the shot instead of ending the flight.
module shot_tracer #(
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(STEP_DIV) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic          fire_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    x_q, y_q, dx_q, dy_q;
    logic [5:0]    err_q;
    logic          sx_q, xmaj_q;
    logic          busy_q, hit_q, miss_q;

    // Launch-time values derived from the live aim inputs.
    logic [4:0] rise_eff, major_l;

    // One candidate step computed from the current registers.
    logic [5:0] major, minor, err_sum, err_d;
    logic       minor_mv, x_mv, y_mv, x_edge, x_wall;
    logic [4:0] x_d, y_d;
    logic       sx_d, step_miss, step_hit;

    always_comb begin
        rise_eff = (run == 5'd0 && rise == 5'd0) ? 5'd1 : rise;
        major_l  = (run >= rise_eff) ? run : rise_eff;
    end

    always_comb begin
        major    = xmaj_q ? {1'b0, dx_q} : {1'b0, dy_q};
        minor    = xmaj_q ? {1'b0, dy_q} : {1'b0, dx_q};
        err_sum  = err_q + minor;
        minor_mv = (err_sum >= major);
        err_d    = minor_mv ? (err_sum - major) : err_sum;
        x_mv     = xmaj_q | minor_mv;
        y_mv     = ~xmaj_q | minor_mv;
        x_edge   = sx_q ? (x_q == 5'd31) : (x_q == 5'd0);
        x_wall   = x_mv & x_edge;
        sx_d     = sx_q;
        x_d      = x_q;
        if (x_mv && !x_edge) begin
            x_d = sx_q ? (x_q + 5'd1) : (x_q - 5'd1);
        end
`ifdef SHOT_BOUNCE_EN
        // Reflect: flip direction and take the step away from the wall.
        if (x_wall) begin
            sx_d = ~sx_q;
            x_d  = sx_q ? (x_q - 5'd1) : (x_q + 5'd1);
        end
        step_miss = y_mv && (y_q == 5'd31);
`else
        step_miss = (y_mv && (y_q == 5'd31)) || x_wall;
`endif
        y_d      = y_mv ? (y_q + 5'd1) : y_q;
        step_hit = (x_d == target_x) && (y_d == target_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fire_q  <= 1'b0;
            cnt_q   <= '0;
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            dx_q    <= 5'd0;
            dy_q    <= 5'd0;
            err_q   <= 6'd0;
            sx_q    <= 1'b0;
            xmaj_q  <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            fire_q <= fire;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire && !fire_q) begin
                        state_q <= FLIGHT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        x_q     <= x_pos;
                        y_q     <= 5'd0;
                        dx_q    <= run;
                        dy_q    <= rise_eff;
                        sx_q    <= dir;
                        xmaj_q  <= (run >= rise_eff);
                        err_q   <= {2'b00, major_l[4:1]};
                    end
                end
                FLIGHT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (step_miss) begin
                            miss_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            x_q   <= x_d;
                            y_q   <= y_d;
                            err_q <= err_d;
                            sx_q  <= sx_d;
                            if (step_hit) begin
                                hit_q   <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign shot_x    = x_q;
    assign shot_y    = y_q;
    assign busy      = busy_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign dbg_state = state_q;

endmodule

// File: doc/shot_tracer.md
Name: shot_tracer

Overview:
- Downstream consumer of the aiming stage.
- On a fire press it latches the aim vector (x_pos, run, rise, dir) and launches a shot from (x_pos, 0) in the 32x32 playfield.
- The shot is stepped one pixel at a time with an integer Bresenham line walk until it hits the target cell or leaves the field.
- Position and status outputs feed the display and scoring stages.

Parameters:
- STEP_DIV, 4, clock cycles per shot step (>=1). The internal step counter is $clog2(STEP_DIV)+1 bits wide.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- fire  input  1  fire button, already debounced; rising edge launches a shot
- x_pos  input  5  launch column from the aiming stage
- run  input  5  horizontal aim magnitude
- rise  input  5  vertical aim magnitude
- dir  input  1  1 = shot moves toward increasing x, 0 = toward decreasing x
- target_x  input  5  target column
- target_y  input  5  target row
- shot_x  output  5  current shot column
- shot_y  output  5  current shot row (0 = launch row, increasing upward)
- busy  output  1  high in FLIGHT and DONE
- hit  output  1  one-cycle pulse: shot reached the target
- miss  output  1  one-cycle pulse: shot left the field

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset state (also applies mid-flight):
  - state = IDLE.
  - shot_x, shot_y, hit, miss, busy, fire edge register and step counter are all 0.
- fire edge detect: fire_q registered each cycle. A launch needs fire=1, fire_q=0 and state IDLE. Edges seen in FLIGHT or DONE are dropped, not queued.
- IDLE -> FLIGHT on launch. On the same edge:
  - shot_x <= x_pos; shot_y <= 0.
  - dx <= run; dy <= rise; sx <= dir.
  - Counter <= 0.
  - If run=0 and rise=0, use dy=1 (straight up).
  - Major axis is x if dx >= dy, otherwise y.
  - err <= floor(major/2). err is a 6-bit unsigned register.
- The launch cell is never hit-checked.
- FLIGHT: the counter increments each cycle and wraps at STEP_DIV-1. A step happens on a cycle where counter == STEP_DIV-1, so the first step is STEP_DIV cycles after entering FLIGHT.
- Step with x major:
  - x moves by +/-1 per sx.
  - err += dy.
  - If err >= dx: err -= dx and y += 1.
- Step with y major:
  - y += 1.
  - err += dx.
  - If err >= dy: err -= dy and x moves by +/-1.
- Step boundary checks use the pre-update position:
  - x would go below 0 or above 31 -> miss.
  - y would go above 31 -> miss.
  - On a miss, position holds and state -> DONE(miss).
- If no miss, the step commits. If the new (x, y) equals (target_x, target_y), state -> DONE(hit); otherwise stay in FLIGHT.
- DONE: hit or miss is high for exactly one cycle, then state -> IDLE. shot_x and shot_y hold their last values until the next launch.
- hit and miss are never high together.
- Aim inputs that change during flight are ignored.
- busy is registered: it rises the cycle after the launch edge and falls on the DONE -> IDLE edge.

Optional Feature:
- Macro: SHOT_BOUNCE_EN.
- Defined: an out-of-range x on a step does not cause a miss. Instead sx is inverted and x moves one cell in the new direction, with the y update applied as normal. Example: x=31 moving +1 goes to 30. The y overflow still causes a miss.
- Not defined: side walls cause a miss as described in Behaviour.

Test Plan:
1. STEP_DIV=1, x_pos=10, run=3, rise=1, dir=1, target (12,1); pulse fire.
   - Path is (11,0) then (12,1).
   - hit pulses exactly one cycle after the second step.
   - miss=0 throughout; busy drops after the hit pulse.
2. STEP_DIV=1, x_pos=5, run=0, rise=0, target (0,0).
   - The shot climbs straight up: y = 1..31 with x=5.
   - The 32nd step causes a miss; shot_y holds at 31.
3. STEP_DIV=1, x_pos=30, run=5, rise=0, dir=1, target (0,31).
   - Without SHOT_BOUNCE_EN: step1 gives x=31; step2 causes a miss.
   - With SHOT_BOUNCE_EN: step2 gives x=30 and the shot keeps moving left.
4. STEP_DIV=4: check step timing and input latching.
   - Steps land at 4, 8, 12... cycles after busy rises.
   - A second fire edge and aim-input changes mid-flight do not alter the trajectory.
   - Holding fire high through DONE does not relaunch; a fresh edge is required.
5. Assert reset mid-flight at step 3.
   - Next cycle: shot_x, shot_y, busy, hit and miss are all 0.
   - No hit or miss pulse is emitted.
   - A fire edge after reset launches normally.
